// File: rtl/countdown_timer.sv
// Loadable, prescaled down-counter with start/busy/done handshake.
// Counts loaded value to zero, then flags done or reloads for periodic ticks.
module countdown_timer #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] loadVal,
  input  logic             start,
  input  logic             pause,
  input  logic             reload_en,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  localparam int unsigned    PC_W    = $clog2(PRESCALE) + 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    DONE
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] reload_reg;
  logic [PC_W-1:0]  pc;

  assign busy = (state == RUN) || (state == PAUSED);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dout       <= '0;
      reload_reg <= '0;
      pc         <= '0;
      tc         <= 1'b0;
    end else if (load) begin
      state      <= IDLE;
      dout       <= loadVal;
      reload_reg <= loadVal;
      pc         <= '0;
      tc         <= 1'b0;
    end else begin
      tc <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (dout != '0) begin
              state <= RUN;
              pc    <= '0;
            end else begin
              state <= DONE;
              tc    <= 1'b1;
            end
          end
        end

        RUN: begin
          if (pause) begin
            state <= PAUSED;
          end else if (pc == PC_LAST) begin
            pc <= '0;
            if (dout > WIDTH'(1)) begin
              dout <= dout - WIDTH'(1);
            end else begin
              // terminal step: reload_en is only looked at here
              tc <= 1'b1;
              if (reload_en) begin
                dout <= reload_reg;
              end else begin
                dout  <= '0;
                state <= DONE;
              end
            end
          end else begin
            pc <= pc + PC_W'(1);
          end
        end

        PAUSED: begin
          if (!pause) state <= RUN;
        end

        DONE: begin
          if (start) begin
            if (reload_reg != '0) begin
              dout  <= reload_reg;
              pc    <= '0;
              state <= RUN;
            end else begin
              tc <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // A running count is never zero; entering RUN always requires a nonzero source.
  always_ff @(posedge clk) begin
    if (!rst && state == RUN) begin
      assert (dout != '0);
      assert (reload_reg != '0);
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: elapsed-time reference model for PRESCALE=1 and 4,
// checked every cycle, plus directed literal expectations.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       reload_en = 1'b0;

  logic [3:0] dout1, dout4;
  logic       busy1, done1, tc1, busy4, done4, tc4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  countdown_timer #(.WIDTH(4), .PRESCALE(1)) u1 (
    .clk(clk), .rst(rst), .load(load), .loadVal(load_val), .start(start),
    .pause(pause), .reload_en(reload_en),
    .dout(dout1), .busy(busy1), .done(done1), .tc(tc1)
  );

  countdown_timer #(.WIDTH(4), .PRESCALE(4)) u4 (
    .clk(clk), .rst(rst), .load(load), .loadVal(load_val), .start(start),
    .pause(pause), .reload_en(reload_en),
    .dout(dout4), .busy(busy4), .done(done4), .tc(tc4)
  );

  // Model: a run is described by its starting value and the number of
  // non-paused running cycles elapsed; count = base - elapsed/prescale.
  typedef struct {
    int val;
    int base;
    int el;
    int rl;
    bit run;
    bit pau;
    bit dn;
    bit tc;
  } model_t;

  model_t m1, m4;
  bit     mvalid = 1'b0;

  function automatic model_t step(model_t m, int p, bit r, bit ld, int lv,
                                  bit st, bit pz, bit re);
    model_t n = m;
    int     src;
    if (r) begin
      n.val = 0; n.rl = 0; n.base = 0; n.el = 0;
      n.run = 0; n.pau = 0; n.dn = 0; n.tc = 0;
    end else if (ld) begin
      n.val = lv; n.rl = lv;
      n.run = 0; n.pau = 0; n.dn = 0; n.tc = 0;
    end else begin
      n.tc = 0;
      if (m.run) begin
        if (pz) begin
          n.run = 0; n.pau = 1;
        end else begin
          n.el = m.el + 1;
          if (n.el == m.base * p) begin
            n.tc = 1;
            if (re) begin
              n.el = 0; n.base = m.rl;
            end else begin
              n.run = 0; n.dn = 1; n.val = 0;
            end
          end
        end
      end else if (m.pau) begin
        if (!pz) begin
          n.pau = 0; n.run = 1;
        end
      end else if (st) begin
        src = m.dn ? m.rl : m.val;
        if (src != 0) begin
          n.run = 1; n.dn = 0; n.base = src; n.el = 0;
        end else begin
          n.tc = 1; n.dn = 1; n.val = 0;
        end
      end
    end
    return n;
  endfunction

  function automatic int exp_dout(model_t m, int p);
    return (m.run || m.pau) ? (m.base - m.el / p) : m.val;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  always @(posedge clk) begin
    m1 = step(m1, 1, rst, load, int'(load_val), start, pause, reload_en);
    m4 = step(m4, 4, rst, load, int'(load_val), start, pause, reload_en);
    if (rst) mvalid = 1'b1;
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("u1.dout", int'(dout1), exp_dout(m1, 1));
      chk("u1.busy", int'(busy1), int'(m1.run || m1.pau));
      chk("u1.done", int'(done1), int'(m1.dn));
      chk("u1.tc",   int'(tc1),   int'(m1.tc));
      chk("u4.dout", int'(dout4), exp_dout(m4, 4));
      chk("u4.busy", int'(busy4), int'(m4.run || m4.pau));
      chk("u4.done", int'(done4), int'(m4.dn));
      chk("u4.tc",   int'(tc4),   int'(m4.tc));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int ntc;

  initial begin
    // reset, then start with nothing loaded
    repeat (2) cyc();
    rst = 1'b0;
    chk("rst_dout", int'(dout1), 0);
    chk("rst_busy", int'(busy1), 0);
    chk("rst_done", int'(done1), 0);
    chk("rst_tc", int'(tc1), 0);
    start = 1'b1; cyc(); start = 1'b0;
    chk("empty_start_done", int'(done1), 1);
    chk("empty_start_tc", int'(tc1), 1);
    cyc();
    chk("empty_start_tc_drop", int'(tc1), 0);

    // one-shot count of 3
    load = 1'b1; load_val = 4'd3; cyc(); load = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    chk("os_d3", int'(dout1), 3);
    chk("os_busy", int'(busy1), 1);
    cyc(); chk("os_d2", int'(dout1), 2);
    cyc(); chk("os_d1", int'(dout1), 1);
    cyc();
    chk("os_d0", int'(dout1), 0);
    chk("os_tc", int'(tc1), 1);
    chk("os_done", int'(done1), 1);
    chk("os_busy_end", int'(busy1), 0);
    cyc();
    chk("os_tc_single", int'(tc1), 0);
    chk("os_done_level", int'(done1), 1);
    repeat (10) cyc();
    start = 1'b1; cyc(); start = 1'b0;
    chk("os_restart_d3", int'(dout1), 3);
    repeat (14) cyc();

    // prescale 4, load 2
    load = 1'b1; load_val = 4'd2; cyc(); load = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    chk("ps_d2_first", int'(dout4), 2);
    repeat (3) cyc(); chk("ps_d2_last", int'(dout4), 2);
    cyc(); chk("ps_d1_first", int'(dout4), 1);
    repeat (3) cyc();
    chk("ps_d1_last", int'(dout4), 1);
    chk("ps_no_tc_yet", int'(tc4), 0);
    cyc();
    chk("ps_tc_at_8", int'(tc4), 1);
    chk("ps_d0", int'(dout4), 0);
    chk("ps_done", int'(done4), 1);
    cyc();

    // pause at dout=3 for 4 cycles
    load = 1'b1; load_val = 4'd5; cyc(); load = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc();
    chk("pz_pre_d3", int'(dout1), 3);
    pause = 1'b1; cyc();
    chk("pz_hold_d3", int'(dout1), 3);
    chk("pz_busy", int'(busy1), 1);
    repeat (3) cyc();
    pause = 1'b0; cyc();
    chk("pz_resume_d3", int'(dout1), 3);
    chk("pz_resume_busy", int'(busy1), 1);
    cyc(); chk("pz_d2", int'(dout1), 2);
    cyc(); chk("pz_d1", int'(dout1), 1);
    cyc();
    chk("pz_tc", int'(tc1), 1);
    chk("pz_done", int'(done1), 1);
    repeat (40) cyc();

    // periodic mode, reload 4
    reload_en = 1'b1;
    load = 1'b1; load_val = 4'd4; cyc(); load = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    ntc = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      ntc += int'(tc1);
    end
    chk("per_tc_count", ntc, 3);
    chk("per_no_done", int'(done1), 0);
    chk("per_reloaded_d4", int'(dout1), 4);
    reload_en = 1'b0;
    repeat (20) cyc();
    chk("per_stop_done", int'(done1), 1);

    // collisions
    load = 1'b1; load_val = 4'd7; start = 1'b1; cyc(); load = 1'b0; start = 1'b0;
    chk("col_ld_st_d7", int'(dout1), 7);
    chk("col_ld_st_idle", int'(busy1), 0);
    cyc(); chk("col_ld_st_norun", int'(busy1), 0);
    start = 1'b1; cyc(); cyc();
    chk("col_st_run_d6", int'(dout1), 6);
    start = 1'b0;
    load = 1'b1; load_val = 4'd9; cyc(); load = 1'b0;
    chk("col_ld_run_idle", int'(busy1), 0);
    chk("col_ld_run_d9", int'(dout1), 9);
    chk("col_ld_run_tc", int'(tc1), 0);
    cyc(); chk("col_ld_run_nodone", int'(done1), 0);
    start = 1'b1; cyc(); start = 1'b0;
    pause = 1'b1; cyc();
    chk("col_paused_busy", int'(busy1), 1);
    rst = 1'b1; cyc(); rst = 1'b0; pause = 1'b0;
    chk("col_rst_dout", int'(dout1), 0);
    chk("col_rst_busy", int'(busy1), 0);
    chk("col_rst_done", int'(done1), 0);
    chk("col_rst_tc", int'(tc1), 0);
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
